inst_fetch: RTL and testbench

INST_FETCH -- requirements
Module: inst_fetch

---
 rtl/inst_fetch.sv | 73 +++++++
 tb/tb_inst_fetch.sv | 133 +++++++++++++
 2 files changed

// File: rtl/inst_fetch.sv
// inst_fetch: sequential instruction fetch into a 2-entry {pc, instruction} buffer with redirect and halt.
// Ports: clk/rst (sync, active-high); fetch_en gates fetching; imem_addr/imem_data is the
// combinational instruction memory; redirect_valid/redirect_pc restart fetch; inst_valid/inst_ready/
// inst_data/inst_pc is the consumer handshake; halt flags end of program with an empty buffer;
// misalign_fault is sticky and only live when FETCH_ALIGN_CHECK_EN is defined.
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int MEM_WORDS = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_en,
  output logic [4:0]  imem_addr,
  input  logic [31:0] imem_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  output logic        halt,
  output logic        misalign_fault
);
  localparam logic [31:0] LIMIT = 32'(MEM_WORDS * 4);
  logic [31:0] pc;
  logic [31:0] fpc [2];
  logic [31:0] fdata [2];
  logic        rd;
  logic [1:0]  count;
  logic        fault, misalign, in_range, pop, push, wr;
  logic [31:0] target;
  assign in_range = pc < LIMIT;
  assign pop = inst_valid & inst_ready;
  assign push = fetch_en & in_range & ~fault & ~redirect_valid & (count != 2'd2 | pop);
  // with two slots the tail is the slot after the head; when full it is the head being popped
  assign wr = rd ^ count[0];
  assign imem_addr = pc[6:2];
  assign inst_valid = count != 2'd0;
  assign inst_data = fdata[rd];
  assign inst_pc = fpc[rd];
  assign halt = ~in_range & (count == 2'd0);
  assign misalign_fault = fault;
`ifdef FETCH_ALIGN_CHECK_EN
  assign misalign = redirect_pc[1:0] != 2'b00;
  assign target = redirect_pc;
  always_ff @(posedge clk)
    if (rst) fault <= 1'b0;
    else if (redirect_valid & misalign) fault <= 1'b1;
`else
  assign misalign = 1'b0;
  assign fault = 1'b0;
  assign target = redirect_pc & ~32'h3;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_PC;
      count <= 2'd0;
      rd <= 1'b0;
    end else if (redirect_valid & ~fault) begin
      count <= 2'd0;
      rd <= 1'b0;
      if (!misalign) pc <= target;
    end else begin
      if (push) begin
        fpc[wr] <= pc;
        fdata[wr] <= imem_data;
        pc <= pc + 32'd4;
      end
      if (pop) rd <= ~rd;
      count <= count + 2'(push) - 2'(pop);
    end
  end
endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch: directed self-checking bench for inst_fetch.
module tb_inst_fetch;
  logic        clk = 1'b0;
  logic        rst, fetch_en, redirect_valid, inst_ready;
  logic [31:0] redirect_pc;
  logic [4:0]  imem_addr, imem_addr1;
  logic [31:0] imem_data, imem_data1, inst_data, inst_pc, inst_data1, inst_pc1;
  logic        inst_valid, halt, misalign_fault, inst_valid1, halt1, misalign_fault1;
  logic [31:0] mem [32];
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  assign imem_data = mem[imem_addr];
  assign imem_data1 = mem[imem_addr1];
  inst_fetch u0 (
    .clk(clk), .rst(rst), .fetch_en(fetch_en), .imem_addr(imem_addr), .imem_data(imem_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .inst_valid(inst_valid),
    .inst_ready(inst_ready), .inst_data(inst_data), .inst_pc(inst_pc), .halt(halt),
    .misalign_fault(misalign_fault)
  );
  inst_fetch #(.MEM_WORDS(4)) u1 (
    .clk(clk), .rst(rst), .fetch_en(fetch_en), .imem_addr(imem_addr1), .imem_data(imem_data1),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .inst_valid(inst_valid1),
    .inst_ready(inst_ready), .inst_data(inst_data1), .inst_pc(inst_pc1), .halt(halt1),
    .misalign_fault(misalign_fault1)
  );
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 32'h1000_0000 + 32'(i);
    mem[0] = 32'h00002083;
    mem[1] = 32'h00402103;
    rst = 1'b1; fetch_en = 1'b1; inst_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0;
    tick();
    chk("rst_valid", 32'(inst_valid), 32'd0);
    chk("rst_halt", 32'(halt), 32'd0);
    chk("rst_fault", 32'(misalign_fault), 32'd0);
    chk("rst_addr", 32'(imem_addr), 32'd0);
    rst = 1'b0;
    tick();
    chk("c1_valid", 32'(inst_valid), 32'd1);
    chk("c1_pc", inst_pc, 32'h0);
    chk("c1_data", inst_data, 32'h00002083);
    tick();
    chk("c2_pc", inst_pc, 32'h4);
    chk("c2_data", inst_data, 32'h00402103);
    rst = 1'b1;
    tick();
    rst = 1'b0; inst_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_data", inst_data, 32'h00002083);
      chk("stall_pc", inst_pc, 32'h0);
    end
    chk("stall_addr", 32'(imem_addr), 32'd2);
    chk("stall_valid", 32'(inst_valid), 32'd1);
    inst_ready = 1'b1;
    tick();
    chk("rel_pc4", inst_pc, 32'h4);
    chk("rel_data4", inst_data, 32'h00402103);
    redirect_valid = 1'b1; redirect_pc = 32'h14;
    tick();
    chk("redir_valid0", 32'(inst_valid), 32'd0);
    chk("redir_addr", 32'(imem_addr), 32'd5);
    redirect_valid = 1'b0;
    tick();
    chk("redir_pc", inst_pc, 32'h14);
    chk("redir_data", inst_data, 32'h1000_0005);
    tick();
    chk("after_redir_pc", inst_pc, 32'h18);
    redirect_valid = 1'b1; redirect_pc = 32'h16;
    tick();
    redirect_valid = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
    chk("mis_fault", 32'(misalign_fault), 32'd1);
    chk("mis_valid", 32'(inst_valid), 32'd0);
    redirect_pc = 32'h0; redirect_valid = 1'b1;
    tick();
    redirect_valid = 1'b0;
    tick();
    chk("mis_sticky", 32'(misalign_fault), 32'd1);
    chk("mis_valid2", 32'(inst_valid), 32'd0);
`else
    chk("mis_fault", 32'(misalign_fault), 32'd0);
    chk("mis_valid", 32'(inst_valid), 32'd0);
    tick();
    chk("mis_pc", inst_pc, 32'h14);
`endif
    rst = 1'b1;
    tick();
    rst = 1'b0; inst_ready = 1'b0;
    tick();
    tick();
    chk("full_addr", 32'(imem_addr), 32'd2);
    rst = 1'b1;
    tick();
    chk("full_rst_valid", 32'(inst_valid), 32'd0);
    chk("full_rst_halt", 32'(halt), 32'd0);
    rst = 1'b0; inst_ready = 1'b1;
    tick();
    chk("post_rst_pc", inst_pc, 32'h0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("h_lastpc", inst_pc1, 32'hC);
    chk("h_nohalt", 32'(halt1), 32'd0);
    tick();
    chk("h_halt", 32'(halt1), 32'd1);
    chk("h_valid", 32'(inst_valid1), 32'd0);
    tick();
    chk("h_halt2", 32'(halt1), 32'd1);
    chk("h_addr", 32'(imem_addr1), 32'd4);
    redirect_valid = 1'b1; redirect_pc = 32'h0;
    tick();
    redirect_valid = 1'b0;
    chk("h_clear", 32'(halt1), 32'd0);
    tick();
    chk("h_rvalid", 32'(inst_valid1), 32'd1);
    chk("h_rpc", inst_pc1, 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
